// File: rtl/chip_test_sequencer.sv
// Vector-driven chip test sequencer: software fills a stimulus FIFO over Avalon-MM,
// then the FSM applies each vector, waits a settle time and scores the response bit.
//
// state  | meaning
// IDLE   | waiting for start; stim_out holds last vector
// APPLY  | drive FIFO head onto stim_out, pop, load settle timer
// SETTLE | settle timer counting down to zero
// SAMPLE | compare synchronised response with expected bit, score it
// DONE   | flag completion, return to IDLE
module chip_test_sequencer #(
    parameter int VEC_W = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic             read,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             in_port,
    output logic [VEC_W-1:0] stim_out,
    output logic             busy,
    output logic             irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state;
    logic            sync_q1, in_sync;
    logic [VEC_W:0]  mem [DEPTH];
    logic [VEC_W:0]  head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      count_field;
    logic [7:0]      settle, settle_cnt;
    logic            irq_en, done, overflow;
    logic            cur_exp, last_exp, last_in;
    logic [15:0]     pass_cnt, fail_cnt;
    logic            wr_ctrl, start, abort, clr, push_req, push_ok, pop, flush;
    logic            full, empty;
    logic            unused_wd;

    assign wr_ctrl     = write && (address == 2'd0);
    assign start       = wr_ctrl && writedata[0];
    assign abort       = wr_ctrl && writedata[1];
    assign clr         = wr_ctrl && writedata[2];
    assign push_req    = write && (address == 2'd1);
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign flush       = abort && (state != S_IDLE);
    assign push_ok     = push_req && !full && !flush;
    assign pop         = (state == S_APPLY) && !flush;
    assign head        = mem[rd_ptr];
    assign count_field = 5'(count);
    assign busy        = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
    assign irq         = done && irq_en;
    assign unused_wd   = ^writedata;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {writedata[16], writedata[VEC_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sync_q1    <= 1'b0;
            in_sync    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            settle     <= 8'd4;
            settle_cnt <= '0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cur_exp    <= 1'b0;
            last_exp   <= 1'b0;
            last_in    <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            stim_out   <= '0;
            readdata   <= '0;
        end else begin
            sync_q1 <= in_port;
            in_sync <= sync_q1;

            if (write && (address == 2'd2)) begin
                settle <= writedata[7:0];
                irq_en <= writedata[8];
            end

            if (clr) begin
                done     <= 1'b0;
                overflow <= 1'b0;
            end
            if (push_req && full)
                overflow <= 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
                if (push_ok && !pop)      count <= count + CNT_ONE;
                else if (!push_ok && pop) count <= count - CNT_ONE;
            end

            // Abort wins over everything the FSM would otherwise do this cycle
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            pass_cnt <= '0;
                            fail_cnt <= '0;
                            state    <= empty ? S_DONE : S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        stim_out   <= head[VEC_W-1:0];
                        cur_exp    <= head[VEC_W];
                        settle_cnt <= settle;
                        state      <= (settle == 8'd0) ? S_SAMPLE : S_SETTLE;
                    end
                    S_SETTLE: begin
                        settle_cnt <= settle_cnt - 8'd1;
                        if (settle_cnt <= 8'd1)
                            state <= S_SAMPLE;
                    end
                    S_SAMPLE: begin
                        if (in_sync == cur_exp) begin
                            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                        end else begin
                            if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                        end
                        last_exp <= cur_exp;
                        last_in  <= in_sync;
                        state    <= empty ? S_DONE : S_APPLY;
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end

            if (read) begin
                case (address)
                    2'd0:    readdata <= {19'd0, count_field, 3'd0, overflow, empty, full, done, busy};
                    2'd1:    readdata <= {30'd0, last_exp, last_in};
                    2'd2:    readdata <= {23'd0, irq_en, settle};
                    default: readdata <= {fail_cnt, pass_cnt};
                endcase
            end
        end
    end

endmodule
